// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS definitions: opcode and funct encodings and the
//               instruction-buffer entry record used by the decode stage and
//               the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    // The PC field is sized for the widest supported PC; narrower PCs are
    // zero-extended on write and truncated on read.
    localparam int unsigned c_ENTRY_PC_W = 32;

    typedef struct packed {
        logic [31:0]             instr;
        logic [c_ENTRY_PC_W-1:0] pc;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Pure combinational MIPS field extraction and classification.
// Ports       : i_instr      - 32-bit instruction word
//               o_opcode .. o_addr26 - raw instruction fields
//               o_is_rtype/o_is_jump/o_is_branch/o_illegal - class flags
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm16,
    output logic [25:0] o_addr26,
    output logic        o_is_rtype,
    output logic        o_is_jump,
    output logic        o_is_branch,
    output logic        o_illegal
);

    assign o_opcode = i_instr[31:26];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    assign o_rd     = i_instr[15:11];
    assign o_shamt  = i_instr[10:6];
    assign o_funct  = i_instr[5:0];
    assign o_imm16  = i_instr[15:0];
    assign o_addr26 = i_instr[25:0];

    assign o_is_rtype  = (o_opcode == c_OP_RTYPE);
    assign o_is_jump   = (o_opcode == c_OP_J)   || (o_opcode == c_OP_JAL);
    assign o_is_branch = (o_opcode == c_OP_BEQ) || (o_opcode == c_OP_BNE);

    always_comb begin
        o_illegal = 1'b1;
        case (o_opcode)
            c_OP_RTYPE: begin
                case (o_funct)
                    c_FN_SLL, c_FN_SRL, c_FN_JR, c_FN_ADD,
                    c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: o_illegal = 1'b0;
                    default:                               o_illegal = 1'b1;
                endcase
            end
            c_OP_J, c_OP_JAL, c_OP_BEQ, c_OP_BNE, c_OP_ADDI, c_OP_SLTI,
            c_OP_ORI, c_OP_LUI, c_OP_LW, c_OP_SW:          o_illegal = 1'b0;
            default:                                       o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Two-entry instruction buffer between fetch and execute with
//               combinational decode of the head entry.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready/in_instr/in_pc   - fetch side handshake
//               flush                              - discard held entries
//               out_valid/out_ready/out_pc/out_instr - consumer handshake
//               opcode..addr26, is_* / illegal     - head entry decode
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import mips_pkg::*;
#(
    parameter int PC_W = 30
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm16,
    output logic [25:0]     addr26,
    output logic            is_jump,
    output logic            is_branch,
    output logic            is_rtype,
    output logic            illegal
);

    logic [1:0] r_count;
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    entry_t     r_entry [2];

    logic       w_accept;
    logic       w_release;
    entry_t     w_in_entry;
    entry_t     w_head;
    logic [31:0] w_head_instr;
    logic       w_unused_pc;
    logic       w_dec_rtype;
    logic       w_dec_jump;
    logic       w_dec_branch;
    logic       w_dec_illegal;

    // Both handshakes depend only on registered occupancy, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid  && in_ready  && !flush;
    assign w_release = out_valid && out_ready && !flush;

    always_comb begin
        w_in_entry                = '0;
        w_in_entry.instr          = in_instr;
        w_in_entry.pc[PC_W-1:0]   = in_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_entry[0] <= '0;
            r_entry[1] <= '0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            // One-bit pointers wrap 1->0 by construction.
            if (w_accept) begin
                r_entry[r_wr_ptr] <= w_in_entry;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_release) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_release})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Everything presented downstream is forced to zero when the head is empty,
    // including the flags (a zero word would otherwise decode as SLL).
    assign w_head       = r_entry[r_rd_ptr];
    assign w_head_instr = out_valid ? w_head.instr : 32'd0;
    assign out_instr    = w_head_instr;
    assign out_pc       = out_valid ? w_head.pc[PC_W-1:0] : '0;
    assign w_unused_pc  = ^w_head.pc;

    instr_decoder u_decoder (
        .i_instr     (w_head_instr),
        .o_opcode    (opcode),
        .o_rs        (rs),
        .o_rt        (rt),
        .o_rd        (rd),
        .o_shamt     (shamt),
        .o_funct     (funct),
        .o_imm16     (imm16),
        .o_addr26    (addr26),
        .o_is_rtype  (w_dec_rtype),
        .o_is_jump   (w_dec_jump),
        .o_is_branch (w_dec_branch),
        .o_illegal   (w_dec_illegal)
    );

    assign is_rtype  = out_valid && w_dec_rtype;
    assign is_jump   = out_valid && w_dec_jump;
    assign is_branch = out_valid && w_dec_branch;
    assign illegal   = out_valid && w_dec_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage: decode vector table,
//               directed buffer corner cases and a randomized run against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int PC_W = 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd, shamt;
    logic [15:0]     imm16;
    logic [25:0]     addr26;
    logic            is_jump, is_branch, is_rtype, illegal;

    decode_stage #(.PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .addr26(addr26),
        .is_jump(is_jump), .is_branch(is_branch), .is_rtype(is_rtype), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } item_t;
    item_t q[$];

    logic [141:0] w_act;
    assign w_act = {out_valid, in_ready, out_pc, out_instr, opcode, rs, rt, rd, shamt,
                    funct, imm16, addr26, is_rtype, is_jump, is_branch, illegal};

    // Reference: what the stage should present, derived from the queue contents.
    function automatic logic [141:0] expected_outs();
        logic [31:0] w;
        int unsigned op, fn;
        logic r, j, b, ill, ok_op, ok_fn;
        if (q.size() == 0)
            return {1'b0, 1'b1, 140'd0};
        w  = q[0].instr;
        op = (w >> 26) & 32'h3F;
        fn = w & 32'h3F;
        r  = (op == 0);
        j  = (op == 2) || (op == 3);
        b  = (op == 4) || (op == 5);
        ok_op = op inside {32'h00, 32'h02, 32'h03, 32'h04, 32'h05, 32'h08,
                           32'h0A, 32'h0D, 32'h0F, 32'h23, 32'h2B};
        ok_fn = fn inside {32'h00, 32'h02, 32'h08, 32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        ill = !ok_op || (r && !ok_fn);
        return {1'b1, (q.size() != 2), q[0].pc, w,
                w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0],
                w[15:0], w[25:0], r, j, b, ill};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare against model, advance model at the edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                       input logic fl, input logic ordy);
        logic acc, rel;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
        #1;
        check("model", w_act, expected_outs());
        acc = v && (q.size() != 2) && !fl;
        rel = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (rel) void'(q.pop_front());
            if (acc) q.push_back('{ins, pc});
        end
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [3:0]  flags;   // {is_rtype, is_jump, is_branch, illegal}
    } vec_t;
    vec_t tbl[16];

    logic [5:0] ops[11];
    logic [5:0] fns[8];

    initial begin
        // Top six bits of 0x08010005 are 000010, so it decodes as a J-format word.
        tbl[0]  = '{32'h08010005, 6'h02, 5'd0, 5'd1, 6'h05, 16'h0005, 4'b0100};
        tbl[1]  = '{32'h00221820, 6'h00, 5'd1, 5'd2, 6'h20, 16'h1820, 4'b1000};
        tbl[2]  = '{32'hFC000000, 6'h3F, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0001};
        tbl[3]  = '{32'h00000001, 6'h00, 5'd0, 5'd0, 6'h01, 16'h0001, 4'b1001};
        tbl[4]  = '{32'h10220003, 6'h04, 5'd1, 5'd2, 6'h03, 16'h0003, 4'b0010};
        tbl[5]  = '{32'h14000000, 6'h05, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0010};
        tbl[6]  = '{32'h0C000010, 6'h03, 5'd0, 5'd0, 6'h10, 16'h0010, 4'b0100};
        tbl[7]  = '{32'h00000008, 6'h00, 5'd0, 5'd0, 6'h08, 16'h0008, 4'b1000};
        tbl[8]  = '{32'h3C010000, 6'h0F, 5'd0, 5'd1, 6'h00, 16'h0000, 4'b0000};
        tbl[9]  = '{32'h8C000000, 6'h23, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0000};
        tbl[10] = '{32'hAC000000, 6'h2B, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0000};
        tbl[11] = '{32'h28000000, 6'h0A, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0000};
        tbl[12] = '{32'h34000000, 6'h0D, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0000};
        tbl[13] = '{32'h20000000, 6'h08, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0000};
        tbl[14] = '{32'h18000000, 6'h06, 5'd0, 5'd0, 6'h00, 16'h0000, 4'b0001};
        tbl[15] = '{32'h0000002B, 6'h00, 5'd0, 5'd0, 6'h2B, 16'h002B, 4'b1001};
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset state
        #2;
        check("reset_model", w_act, expected_outs());
        check("reset_hs", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Decode table, streamed back-to-back: every cycle shows the word just accepted
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, tbl[i].instr, PC_W'(32'h10 + i), 1'b0, 1'b1);
            check("tbl_fields", {out_valid, in_ready, out_pc, opcode, rs, rt, funct, imm16,
                                 is_rtype, is_jump, is_branch, illegal},
                  {1'b1, 1'b1, PC_W'(32'h10 + i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   tbl[i].fn, tbl[i].imm, tbl[i].flags});
        end
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
        check("drained", {out_valid, in_ready, out_instr}, {1'b0, 1'b1, 32'h0});

        // Fill while stalled; a third word is refused; drain preserves order
        cyc(1'b1, 32'h00221820, PC_W'(32'h20), 1'b0, 1'b0);
        cyc(1'b1, 32'h08000004, PC_W'(32'h21), 1'b0, 1'b0);
        check("full_ready", in_ready, 1'b0);
        cyc(1'b1, 32'hDEADBEEF, PC_W'(32'h22), 1'b0, 1'b0);
        check("head_first", {out_instr, is_rtype, funct}, {32'h00221820, 1'b1, 6'h20});
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
        check("head_second", {out_instr, is_jump, addr26}, {32'h08000004, 1'b1, 26'h4});
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
        check("empty_again", out_valid, 1'b0);

        // Full with out_ready: release happens, input refused, accept next cycle
        cyc(1'b1, 32'h20010001, PC_W'(32'h30), 1'b0, 1'b0);
        cyc(1'b1, 32'h20020002, PC_W'(32'h31), 1'b0, 1'b0);
        cyc(1'b1, 32'h20030003, PC_W'(32'h32), 1'b0, 1'b1);
        check("full_release", {out_instr, in_ready}, {32'h20020002, 1'b1});
        cyc(1'b1, 32'h20030003, PC_W'(32'h32), 1'b0, 1'b1);
        check("accept_after_full", out_instr, 32'h20030003);
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);

        // Flush with simultaneous push and pop
        cyc(1'b1, 32'h20040004, PC_W'(32'h40), 1'b0, 1'b0);
        cyc(1'b1, 32'h20050005, PC_W'(32'h41), 1'b0, 1'b0);
        cyc(1'b1, 32'h20060006, PC_W'(32'h42), 1'b1, 1'b1);
        check("flush", {out_valid, in_ready, out_instr}, {1'b0, 1'b1, 32'h0});
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
        check("flush_no_ghost", out_valid, 1'b0);

        // Asynchronous reset mid-cycle with a full buffer
        cyc(1'b1, 32'h20070007, PC_W'(32'h50), 1'b0, 1'b0);
        cyc(1'b1, 32'h20080008, PC_W'(32'h51), 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst", w_act, {1'b0, 1'b1, 140'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 32'h20090009, PC_W'(32'h60), 1'b0, 1'b0);
        check("first_after_rst", {out_valid, out_instr}, {1'b1, 32'h20090009});
        cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);

        // Randomized traffic against the queue model
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:26] = ops[$urandom_range(0, 10)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 1) == 1) ins[5:0] = fns[$urandom_range(0, 7)];
            cyc($urandom_range(0, 99) < 70, ins, PC_W'($urandom),
                $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
